// File: rtl/fc_layer_stream_pkg.sv
// Shared types and helpers for the streaming fully-connected layer.
package fc_pkg;

   typedef enum logic [1:0] {LOAD_X, COMPUTE, DRAIN} state_t;

   // Widest accumulator the activation helper accepts.
   localparam int ACC_MAX = 64;

   // Accumulator width: full product plus headroom for N additions.
   function automatic int acc_width(input int t, input int n);
      return 2 * t + $clog2(n);
   endfunction

   // Activation: optional ReLU, then optional clamp to the t-bit signed range.
   // Without clamping the caller keeps the low t bits (plain truncation).
   function automatic logic signed [ACC_MAX-1:0] sat_relu(
      input logic signed [ACC_MAX-1:0] a,
      input int                        t,
      input bit                        relu,
      input bit                        sat
   );
      logic signed [ACC_MAX-1:0] v, hi, lo;
      v  = a;
      hi = (ACC_MAX'(1) <<< (t - 1)) - ACC_MAX'(1);
      lo = -hi - ACC_MAX'(1);
      if (relu && (v < 0)) v = '0;
      if (sat) begin
         if (v > hi)      v = hi;
         else if (v < lo) v = lo;
      end
      return v;
   endfunction

endpackage

// File: rtl/fc_layer_stream_if.sv
// Stream-in, stream-out and weight-load bundle of the FC layer.
// master = upstream/downstream environment, slave = the layer itself.
interface fc_layer_stream_if #(
   parameter int T  = 16,
   parameter int AW = 7
);
   logic          input_valid;
   logic          input_ready;
   logic [T-1:0]  input_data;
   logic          output_valid;
   logic          output_ready;
   logic [T-1:0]  output_data;
   logic          wl_valid;
   logic [AW-1:0] wl_addr;
   logic [T-1:0]  wl_data;
   logic          busy;

   modport master (
      output input_valid, input_data, output_ready, wl_valid, wl_addr, wl_data,
      input  input_ready, output_valid, output_data, busy
   );

   modport slave (
      input  input_valid, input_data, output_ready, wl_valid, wl_addr, wl_data,
      output input_ready, output_valid, output_data, busy
   );
endinterface

// File: rtl/fc_layer_stream_mac_lane.sv
// One MAC lane: private weight bank, registered read, multiplier and accumulator.
module fc_mac_lane
   import fc_pkg::*;
#(
   parameter int T     = 16,
   parameter int DEPTH = 64,
   parameter int AW    = acc_width(16, 8),
   parameter int BAW   = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                we_i,
   input  logic [BAW-1:0]      waddr_i,
   input  logic [T-1:0]        wdata_i,
   input  logic                re_i,
   input  logic [BAW-1:0]      raddr_i,
   input  logic signed [T-1:0] x_i,
   input  logic                clr_i,
   input  logic                acc_en_i,
   output logic [AW-1:0]       acc_o
);
   logic [T-1:0]          mem [DEPTH];
   logic signed [T-1:0]   w_q;
   logic signed [2*T-1:0] prod;
   logic signed [AW-1:0]  acc_q, acc_d;

   // Weight bank write port; contents survive reset on purpose.
   always_ff @(posedge clk) begin
      if (we_i) mem[waddr_i] <= wdata_i;
   end

   // Registered read: weight arrives one cycle after its column is issued.
   always_ff @(posedge clk) begin
      if (reset)     w_q <= '0;
      else if (re_i) w_q <= mem[raddr_i];
   end

   assign prod = (2*T)'(w_q) * (2*T)'(x_i);

   // Clear wins over accumulate so a new group starts from zero.
   always_comb begin
      acc_d = acc_q;
      if (clr_i)         acc_d = '0;
      else if (acc_en_i) acc_d = acc_q + AW'(prod);
   end

   // Accumulator register.
   always_ff @(posedge clk) begin
      if (reset) acc_q <= '0;
      else       acc_q <= acc_d;
   end

   assign acc_o = acc_q;
endmodule

// File: rtl/fc_layer_stream.sv
// Streaming fully-connected layer y = f(W*x) with P parallel MAC lanes.
// Rows g*P..g*P+P-1 are computed together; group g walks 0..M/P-1.
module fc_layer_stream
   import fc_pkg::*;
#(
   parameter int M    = 16,
   parameter int N    = 8,
   parameter int T    = 16,
   parameter int P    = 2,
   parameter int RELU = 1,
   parameter int SAT  = 1
) (
   input logic              clk,
   input logic              reset,
   fc_layer_stream_if.slave bus
);
   localparam int G     = M / P;
   localparam int DEPTH = G * N;
   localparam int BAW   = $clog2(DEPTH);
   localparam int AW    = acc_width(T, N);
   localparam int XW    = $clog2(N);
   localparam int JW    = $clog2(N + 1);
   localparam int GW    = (G > 1) ? $clog2(G) : 1;
   localparam int LW    = (P > 1) ? $clog2(P) : 1;

   if (M % P != 0) begin : g_bad_mp
      $error("fc_layer_stream: M must be a multiple of P");
   end
   if (N < 2) begin : g_bad_n
      $error("fc_layer_stream: N must be at least 2");
   end

   state_t               state_q, state_d;
   logic [XW-1:0]        x_cnt_q, x_cnt_d;
   logic [JW-1:0]        j_q, j_d;
   logic [GW-1:0]        g_q, g_d;
   logic [LW-1:0]        lane_q, lane_d;
   logic                 cap_q, cap_d;
   logic                 out_vld_q, out_vld_d;
   logic                 rdy_en_q, acc_en_q;
   logic [P-1:0][T-1:0]  buf_q, buf_d, f_val;
   logic [P-1:0][AW-1:0] acc;
   logic [T-1:0]         x_mem [N];
   logic [T-1:0]         x_rd_q;
   logic                 in_hs, out_hs, iss, clr, wl_we;
   logic [LW-1:0]        wl_bank;
   logic [BAW-1:0]       wl_baddr, rd_addr;
   int                   wl_row, wl_col;

   assign bus.input_ready  = rdy_en_q && (state_q == LOAD_X);
   assign bus.output_valid = out_vld_q;
   assign bus.output_data  = buf_q[lane_q];
   assign bus.busy         = (state_q != LOAD_X);

   assign in_hs   = bus.input_valid && bus.input_ready;
   assign out_hs  = out_vld_q && bus.output_ready;
   assign iss     = (state_q == COMPUTE) && (j_q != JW'(N));
   assign clr     = (state_q == COMPUTE) && (j_q == '0);
   assign rd_addr = BAW'(int'(g_q) * N + int'(j_q));

   // Flat weight index -> (bank, bank address); writes only while idle.
   always_comb begin
      wl_row   = int'(bus.wl_addr) / N;
      wl_col   = int'(bus.wl_addr) % N;
      wl_bank  = LW'(wl_row % P);
      wl_baddr = BAW'((wl_row / P) * N + wl_col);
      wl_we    = bus.wl_valid && (state_q == LOAD_X) && (x_cnt_q == '0)
                 && !in_hs && (wl_row < M);
   end

   for (genvar p = 0; p < P; p++) begin : g_lane
      fc_mac_lane #(.T(T), .DEPTH(DEPTH), .AW(AW)) u_lane (
         .clk      (clk),
         .reset    (reset),
         .we_i     (wl_we && (wl_bank == LW'(p))),
         .waddr_i  (wl_baddr),
         .wdata_i  (bus.wl_data),
         .re_i     (iss),
         .raddr_i  (rd_addr),
         .x_i      (x_rd_q),
         .clr_i    (clr),
         .acc_en_i (acc_en_q),
         .acc_o    (acc[p])
      );
   end

   // Activation of every lane's accumulator, ready for capture in DRAIN.
   always_comb begin
      f_val = '0;
      for (int p = 0; p < P; p++)
         f_val[p] = T'(sat_relu(ACC_MAX'($signed(acc[p])), T, RELU != 0, SAT != 0));
   end

   // x vector store; read column j alongside the weight banks.
   always_ff @(posedge clk) begin
      if (in_hs) x_mem[x_cnt_q] <= bus.input_data;
   end

   // Registered x read, aligned with the lanes' weight read.
   always_ff @(posedge clk) begin
      if (reset)    x_rd_q <= '0;
      else if (iss) x_rd_q <= x_mem[j_q[XW-1:0]];
   end

   // Next-state and counter logic of the LOAD_X / COMPUTE / DRAIN sequence.
   always_comb begin
      state_d   = state_q;
      x_cnt_d   = x_cnt_q;
      j_d       = j_q;
      g_d       = g_q;
      lane_d    = lane_q;
      cap_d     = cap_q;
      out_vld_d = out_vld_q;
      buf_d     = buf_q;
      unique case (state_q)
         LOAD_X: begin
            if (in_hs) begin
               if (x_cnt_q == XW'(N - 1)) begin
                  x_cnt_d = '0;
                  j_d     = '0;
                  g_d     = '0;
                  state_d = COMPUTE;
               end else begin
                  x_cnt_d = x_cnt_q + XW'(1);
               end
            end
         end
         COMPUTE: begin
            // Column N is the extra cycle where the last product lands.
            if (j_q == JW'(N)) begin
               j_d     = '0;
               cap_d   = 1'b0;
               state_d = DRAIN;
            end else begin
               j_d = j_q + JW'(1);
            end
         end
         DRAIN: begin
            if (!cap_q) begin
               buf_d     = f_val;
               cap_d     = 1'b1;
               out_vld_d = 1'b1;
               lane_d    = '0;
            end else if (out_hs) begin
               if (lane_q == LW'(P - 1)) begin
                  out_vld_d = 1'b0;
                  cap_d     = 1'b0;
                  if (g_q == GW'(G - 1)) begin
                     g_d     = '0;
                     state_d = LOAD_X;
                  end else begin
                     g_d     = g_q + GW'(1);
                     state_d = COMPUTE;
                  end
               end else begin
                  lane_d = lane_q + LW'(1);
               end
            end
         end
         default: state_d = LOAD_X;
      endcase
   end

   // State and control registers; input_ready stays low the cycle after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= LOAD_X;
         x_cnt_q   <= '0;
         j_q       <= '0;
         g_q       <= '0;
         lane_q    <= '0;
         cap_q     <= 1'b0;
         out_vld_q <= 1'b0;
         buf_q     <= '0;
         rdy_en_q  <= 1'b0;
         acc_en_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_cnt_q   <= x_cnt_d;
         j_q       <= j_d;
         g_q       <= g_d;
         lane_q    <= lane_d;
         cap_q     <= cap_d;
         out_vld_q <= out_vld_d;
         buf_q     <= buf_d;
         rdy_en_q  <= 1'b1;
         acc_en_q  <= iss;
      end
   end
endmodule

// File: tb/tb_fc_layer_stream.sv
// Bench for fc_layer_stream: two instances (RELU=1/SAT=1 and RELU=0/SAT=0)
// share one stimulus; a matrix-vector model predicts every output element.
module tb_fc_layer_stream;
   localparam int M = 16, N = 8, T = 16, P = 2;
   localparam int WAW = $clog2(M * N);

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fc_layer_stream_if #(.T(T), .AW(WAW)) ifa ();
   fc_layer_stream_if #(.T(T), .AW(WAW)) ifb ();

   fc_layer_stream #(.M(M), .N(N), .T(T), .P(P), .RELU(1), .SAT(1)) dut_a (
      .clk(clk), .reset(reset), .bus(ifa));
   fc_layer_stream #(.M(M), .N(N), .T(T), .P(P), .RELU(0), .SAT(0)) dut_b (
      .clk(clk), .reset(reset), .bus(ifb));

   logic           in_valid, out_ready, wl_valid;
   logic [T-1:0]   in_data, wl_data;
   logic [WAW-1:0] wl_addr;

   assign ifa.input_valid  = in_valid;   assign ifb.input_valid  = in_valid;
   assign ifa.input_data   = in_data;    assign ifb.input_data   = in_data;
   assign ifa.output_ready = out_ready;  assign ifb.output_ready = out_ready;
   assign ifa.wl_valid     = wl_valid;   assign ifb.wl_valid     = wl_valid;
   assign ifa.wl_addr      = wl_addr;    assign ifb.wl_addr      = wl_addr;
   assign ifa.wl_data      = wl_data;    assign ifb.wl_data      = wl_data;

   int n_cmp = 0, n_bad = 0;
   int W [M][N];
   int xv [N];
   int exp_a[$], exp_b[$], log_a[$], log_b[$];
   int e_a, e_b;
   logic prev_stall_a = 1'b0, prev_stall_b = 1'b0;
   logic [T-1:0] held_a, held_b;

   task automatic chk(string name, longint act, longint req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic fail_now(string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got an expired bound or unexpected event, required none", name);
   endtask

   // y element from the layer definition: ReLU first, then clamp or truncate.
   function automatic int f_model(longint s, bit relu, bit sat);
      if (relu && s < 0) s = 0;
      if (sat) begin
         if (s > 32767)       s = 32767;
         else if (s < -32768) s = -32768;
         return int'(s);
      end
      return int'(shortint'(s));
   endfunction

   task automatic push_expected();
      for (int r = 0; r < M; r++) begin
         longint s;
         s = 0;
         for (int c = 0; c < N; c++) s += longint'(W[r][c]) * longint'(xv[c]);
         exp_a.push_back(f_model(s, 1'b1, 1'b1));
         exp_b.push_back(f_model(s, 1'b0, 1'b0));
      end
   endtask

   task automatic load_weights();
      for (int r = 0; r < M; r++)
         for (int c = 0; c < N; c++) begin
            wl_valid = 1'b1;
            wl_addr  = WAW'(r * N + c);
            wl_data  = T'(W[r][c]);
            @(posedge clk); #1;
         end
      wl_valid = 1'b0;
   endtask

   task automatic send_vector(input bit spam);
      for (int i = 0; i < N; i++) begin
         int k;
         in_valid = 1'b1;
         in_data  = T'(xv[i]);
         if (spam) begin
            wl_valid = 1'b1;
            wl_addr  = '0;
            wl_data  = T'(99);
         end
         k = 0;
         while (!ifa.input_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
         end
         if (k >= 50) fail_now("input_ready_timeout");
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int k;
      k = 0;
      while ((exp_a.size() != 0 || exp_b.size() != 0) && k < 3000) begin
         @(posedge clk); #1;
         k++;
      end
      if (k >= 3000) fail_now("drain_timeout");
      repeat (5) begin @(posedge clk); #1; end
      chk("idle_valid_a", ifa.output_valid, 0);
      chk("idle_busy_b", ifb.busy, 0);
   endtask

   task automatic set_identity();
      for (int r = 0; r < M; r++)
         for (int c = 0; c < N; c++) W[r][c] = (r < 8 && r == c % 8) ? 1 : 0;
   endtask

   task automatic set_all(input int v);
      for (int r = 0; r < M; r++)
         for (int c = 0; c < N; c++) W[r][c] = v;
   endtask

   // Scoreboard: every accepted output against the model, and hold-while-stalled.
   always @(negedge clk) begin
      if (reset) begin
         prev_stall_a = 1'b0;
         prev_stall_b = 1'b0;
      end else begin
         if (prev_stall_a) begin
            chk("stall_valid_a", ifa.output_valid, 1);
            chk("stall_data_a", ifa.output_data, held_a);
         end
         if (prev_stall_b) begin
            chk("stall_valid_b", ifb.output_valid, 1);
            chk("stall_data_b", ifb.output_data, held_b);
         end
         if (ifa.output_valid && out_ready) begin
            if (exp_a.size() == 0) fail_now("extra_output_a");
            else begin
               e_a = exp_a.pop_front();
               chk("y_a", $signed(ifa.output_data), e_a);
               log_a.push_back(int'($signed(ifa.output_data)));
            end
         end
         if (ifb.output_valid && out_ready) begin
            if (exp_b.size() == 0) fail_now("extra_output_b");
            else begin
               e_b = exp_b.pop_front();
               chk("y_b", $signed(ifb.output_data), e_b);
               log_b.push_back(int'($signed(ifb.output_data)));
            end
         end
         prev_stall_a = ifa.output_valid && !out_ready;
         prev_stall_b = ifb.output_valid && !out_ready;
         held_a = ifa.output_data;
         held_b = ifb.output_data;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, required finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      wl_valid = 1'b0; wl_addr = '0; wl_data = '0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      chk("rst_input_ready", ifa.input_ready, 0);
      chk("rst_output_valid", ifa.output_valid, 0);
      chk("rst_output_data", ifa.output_data, 0);
      chk("rst_busy", ifa.busy, 0);
      @(posedge clk); #1;
      chk("rst_input_ready_next", ifa.input_ready, 1);

      // 1: identity rows 0-7, latency
      set_identity();
      load_weights();
      for (int i = 0; i < N; i++) xv[i] = i + 1;
      log_a.delete(); log_b.delete();
      send_vector(1'b0);
      push_expected();
      k = 0;
      do begin
         @(posedge clk); #1;
         k++;
         if (k == 1) chk("busy_compute", ifa.busy, 1);
      end while (!ifa.output_valid && k < 40);
      chk("latency", k, 10);
      wait_drain();
      chk("t1_count", log_a.size(), 16);
      chk("t1_y0", log_a[0], 1);
      chk("t1_y7", log_a[7], 8);
      chk("t1_y8", log_a[8], 0);
      chk("t1_b_y3", log_b[3], 4);

      // 2: all -1, ReLU vs linear
      set_all(-1);
      load_weights();
      log_a.delete(); log_b.delete();
      send_vector(1'b0);
      push_expected();
      wait_drain();
      chk("t2_relu_y0", log_a[0], 0);
      chk("t2_lin_y0", log_b[0], -36);
      chk("t2_lin_y15", log_b[15], -36);

      // 3: saturation vs truncation
      set_all(32767);
      load_weights();
      for (int i = 0; i < N; i++) xv[i] = 32767;
      log_a.delete(); log_b.delete();
      send_vector(1'b0);
      push_expected();
      wait_drain();
      chk("t3_sat_y0", log_a[0], 32767);
      chk("t3_trunc_y0", log_b[0], 8);

      // 4: 20-cycle stall in the middle of a DRAIN
      set_identity();
      load_weights();
      for (int i = 0; i < N; i++) xv[i] = 100 * (i + 1);
      log_a.delete(); log_b.delete();
      send_vector(1'b0);
      push_expected();
      k = 0;
      while (log_a.size() < 3 && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      if (k >= 200) fail_now("stall_setup_timeout");
      out_ready = 1'b0;
      repeat (20) begin @(posedge clk); #1; end
      out_ready = 1'b1;
      wait_drain();
      chk("t4_count", log_a.size(), 16);
      chk("t4_y2", log_a[2], 300);
      chk("t4_y3", log_a[3], 400);

      // 5: reset during COMPUTE, weights retained
      for (int i = 0; i < N; i++) xv[i] = i + 5;
      send_vector(1'b0);
      repeat (3) begin @(posedge clk); #1; end
      chk("t5_busy_before", ifa.busy, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("t5_valid_after_rst", ifa.output_valid, 0);
      chk("t5_busy_after_rst", ifa.busy, 0);
      chk("t5_ready_after_rst", ifa.input_ready, 0);
      exp_a.delete(); exp_b.delete();
      reset = 1'b0;
      for (int i = 0; i < N; i++) xv[i] = 2 * (i + 1);
      log_a.delete(); log_b.delete();
      send_vector(1'b0);
      push_expected();
      wait_drain();
      chk("t5_y0", log_a[0], 2);
      chk("t5_y7", log_a[7], 16);
      chk("t5_y15", log_a[15], 0);

      // 6: weight writes while streaming and computing must be dropped
      xv = '{3, 1, 4, 1, 5, 9, 2, 6};
      log_a.delete(); log_b.delete();
      send_vector(1'b1);
      repeat (4) begin @(posedge clk); #1; end
      wl_valid = 1'b0;
      push_expected();
      wait_drain();
      chk("t6_y0", log_a[0], 3);
      chk("t6_y5", log_b[5], 9);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
